// File: rtl/lh_message_sequencer.sv
// Host byte stream to light_hash single-byte pulse handshake: FIFO buffering,
// 0xFF / message / 0x00 framing, digest capture and abort reporting.
module lh_message_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       hash_byte,
  output logic             hash_valid,
  input  logic             hash_busy,
  input  logic [63:0]      hash_digest,
  input  logic             hash_digest_ready,
  input  logic             hash_err,
  output logic [63:0]      digest,
  output logic             digest_valid,
  output logic [CNT_W-1:0] byte_count,
  output logic             msg_err,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_GAP, S_FETCH, S_SETTLE, S_WAIT_BUSY, S_END, S_WAIT_DIG, S_FLUSH
  } state_t;

  state_t          state;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [9:0]      mem [DEPTH];
  logic [9:0]      head;
  logic            full, empty;
  logic            drop;
  logic            accept, reserved, push, pop, in_scope;
  logic [9:0]      push_data;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0]   timer;
  logic            aborted, cur_last;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !rst && !full;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign busy     = (state != S_IDLE);

  assign accept    = in_valid && in_ready;
  assign reserved  = (in_byte == 8'h00) || (in_byte == 8'hFF);
  assign push      = accept && !drop;
  assign push_data = reserved ? {1'b1, 1'b1, 8'h00} : {1'b0, in_last, in_byte};
  assign in_scope  = (state == S_START) || (state == S_GAP) || (state == S_FETCH) ||
                     (state == S_SETTLE) || (state == S_WAIT_BUSY);
  // FETCH defers to a pending hash_err; FLUSH stops once this message's last entry is gone
  assign pop = !empty && (((state == S_FETCH) && !hash_err) ||
                          ((state == S_FLUSH) && !cur_last));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else begin
      if (accept) begin
        if (drop) begin
          if (in_last) drop <= 1'b0;
        end else if (reserved && !in_last) begin
          drop <= 1'b1;
        end
      end
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      hash_byte    <= '0;
      hash_valid   <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      byte_count   <= '0;
      msg_err      <= 1'b0;
      cnt          <= '0;
      timer        <= '0;
      aborted      <= 1'b0;
      cur_last     <= 1'b0;
    end else begin
      hash_valid   <= 1'b0;
      digest_valid <= 1'b0;
      msg_err      <= 1'b0;
      if (in_scope && hash_err) begin
        aborted <= 1'b1;
        state   <= S_FLUSH;
      end else begin
        case (state)
          S_IDLE: if (!empty) begin
            hash_byte  <= 8'hFF;
            hash_valid <= 1'b1;
            cnt        <= '0;
            aborted    <= 1'b0;
            cur_last   <= 1'b0;
            state      <= S_START;
          end
          S_START: state <= S_GAP;
          S_GAP:   state <= S_FETCH;
          S_FETCH: if (!empty) begin
            cur_last   <= head[8];
            hash_valid <= 1'b1;
            if (head[9]) begin
              aborted   <= 1'b1;
              hash_byte <= 8'h00;
              state     <= S_END;
            end else begin
              hash_byte <= head[7:0];
              cnt       <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
              state     <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            timer <= '0;
            state <= S_WAIT_BUSY;
          end
          S_WAIT_BUSY: begin
            if (!hash_busy) begin
              if (cur_last) begin
                hash_byte  <= 8'h00;
                hash_valid <= 1'b1;
                state      <= S_END;
              end else begin
                state <= S_FETCH;
              end
            end else if (timer == TIMER_LAST) begin
              aborted    <= 1'b1;
              hash_byte  <= 8'h00;
              hash_valid <= 1'b1;
              state      <= S_END;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_END: begin
            timer <= '0;
            state <= S_WAIT_DIG;
          end
          S_WAIT_DIG: begin
            if (hash_digest_ready) begin
              if (aborted) begin
                msg_err <= 1'b1;
              end else begin
                digest       <= hash_digest;
                byte_count   <= cnt;
                digest_valid <= 1'b1;
              end
              state <= S_IDLE;
            end else if (timer == TIMER_LAST) begin
              msg_err <= 1'b1;
              state   <= S_IDLE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_FLUSH: begin
            if (cur_last) begin
              hash_byte  <= 8'h00;
              hash_valid <= 1'b1;
              state      <= S_END;
            end else if (!empty) begin
              cur_last <= head[8];
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lh_message_sequencer.sv
// Randomized and directed bench for lh_message_sequencer against a message-level
// expectation model and a stand-in light_hash responder.
module tb_lh_message_sequencer;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 200;
  localparam int unsigned CNT_W   = 5;
  localparam int          CNT_MAX = 31;
  localparam logic [63:0] HINIT   = 64'hcbf2_9ce4_8422_2325;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_byte;
  logic             in_valid, in_last, in_ready;
  logic [7:0]       hash_byte;
  logic             hash_valid, hash_busy, hash_digest_ready, hash_err;
  logic [63:0]      hash_digest, digest;
  logic             digest_valid, msg_err, busy;
  logic [CNT_W-1:0] byte_count;

  always #5 clk = ~clk;

  lh_message_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .hash_byte(hash_byte), .hash_valid(hash_valid), .hash_busy(hash_busy),
    .hash_digest(hash_digest), .hash_digest_ready(hash_digest_ready), .hash_err(hash_err),
    .digest(digest), .digest_valid(digest_valid), .byte_count(byte_count), .msg_err(msg_err),
    .busy(busy)
  );

  typedef struct {
    bit          is_err;
    logic [63:0] dig;
    int          cnt;
  } res_t;

  int          n_cmp = 0, n_err = 0;
  logic [7:0]  exp_pulse[$];
  res_t        exp_res[$];
  logic [7:0]  msg[$];
  logic [63:0] last_digest = '0;
  int          busy_lat = 0, err_at = 0, pulse_cnt = 0, stalls = 0, dv_cnt = 0, me_cnt = 0;

  function automatic logic [63:0] hstep(input logic [63:0] h, input logic [7:0] b);
    return (h ^ {56'd0, b}) * 64'h0000_0100_0000_01b3;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Stand-in light_hash: FNV-style accumulate, optional busy window and error injection
  initial begin
    int busy_cnt = 0, dig_cnt = 0, idx = 0;
    logic [63:0] hacc = HINIT;
    hash_busy = 1'b0; hash_err = 1'b0; hash_digest_ready = 1'b0; hash_digest = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0; dig_cnt = 0; idx = 0;
        hash_busy = 1'b0; hash_err = 1'b0; hash_digest_ready = 1'b0;
      end else begin
        hash_err = 1'b0;
        hash_digest_ready = 1'b0;
        if (hash_valid) chk("pulse_while_busy", 64'(busy_cnt > 0), 64'd0);
        if (busy_cnt > 0) busy_cnt--;
        hash_busy = (busy_cnt > 0);
        if (dig_cnt > 0) begin
          dig_cnt--;
          if (dig_cnt == 0) begin
            hash_digest = hacc;
            hash_digest_ready = 1'b1;
          end
        end
        if (hash_valid) begin
          pulse_cnt++;
          if (hash_byte == 8'hFF) begin
            hacc = HINIT;
            idx = 0;
          end else if (hash_byte == 8'h00) begin
            dig_cnt = 3;
          end else begin
            hacc = hstep(hacc, hash_byte);
            idx++;
            if (busy_lat > 0) begin
              busy_cnt = busy_lat;
              hash_busy = 1'b1;
            end
            if (idx == err_at) hash_err = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: pulses and per-message results against the expectation queues
  initial begin
    bit prev_hv = 1'b0;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hv = 1'b0;
      end else begin
        if (hash_valid) begin
          chk("hv_consecutive", 64'(prev_hv), 64'd0);
          if (exp_pulse.size() == 0) fail_now("unexpected_pulse", $sformatf("got %h required none", hash_byte));
          else chk("hash_byte", 64'(hash_byte), 64'(exp_pulse.pop_front()));
        end
        if (digest_valid) begin
          dv_cnt++;
          if (exp_res.size() == 0) fail_now("unexpected_digest", $sformatf("got %h required none", digest));
          else begin
            r = exp_res.pop_front();
            chk("result_kind_digest", 64'(r.is_err), 64'd0);
            chk("digest", digest, r.dig);
            chk("byte_count", 64'(byte_count), 64'(r.cnt));
            last_digest = r.dig;
          end
        end
        if (msg_err) begin
          me_cnt++;
          if (exp_res.size() == 0) fail_now("unexpected_msg_err", "got 1 required 0");
          else begin
            r = exp_res.pop_front();
            chk("result_kind_err", 64'(r.is_err), 64'd1);
            chk("digest_held", digest, last_digest);
          end
        end
        prev_hv = hash_valid;
      end
    end
  end

  task automatic load_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic send_beat(input logic [7:0] b, input bit l);
    int g = 0;
    in_valid = 1'b1; in_byte = b; in_last = l;
    while (!in_ready && g < 2000) begin
      stalls++;
      @(negedge clk);
      g++;
    end
    if (g >= 2000) fail_now("in_ready_timeout", "got 0 required 1");
    @(negedge clk);
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0; in_byte = 8'($urandom);
  endtask

  // Expected behaviour of one message derived from its host-level bytes
  task automatic send_msg(input int err_inj);
    int n, k, p;
    bit ab;
    res_t r;
    logic [63:0] h;
    n = msg.size(); k = -1;
    for (int i = 0; i < n; i++) if (k < 0 && (msg[i] == 8'h00 || msg[i] == 8'hFF)) k = i;
    p = (k >= 0) ? k : n;
    ab = (k >= 0);
    if (err_inj > 0 && err_inj <= p) begin p = err_inj; ab = 1'b1; end
    exp_pulse.push_back(8'hFF);
    for (int i = 0; i < p; i++) exp_pulse.push_back(msg[i]);
    exp_pulse.push_back(8'h00);
    h = HINIT;
    for (int i = 0; i < n; i++) h = hstep(h, msg[i]);
    r.is_err = ab; r.dig = h; r.cnt = (n > CNT_MAX) ? CNT_MAX : n;
    exp_res.push_back(r);
    for (int i = 0; i < n; i++) send_beat(msg[i], i == n - 1);
  endtask

  task automatic wait_idle();
    int g = 0;
    idle_in();
    while ((exp_pulse.size() != 0 || exp_res.size() != 0 || busy) && g < 6000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 6000) fail_now("idle_timeout", $sformatf("got %0d pending required 0", exp_pulse.size() + exp_res.size()));
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hash_valid"}, 64'(hash_valid), 64'd0);
    chk({tag, "_hash_byte"}, 64'(hash_byte), 64'd0);
    chk({tag, "_digest"}, digest, 64'd0);
    chk({tag, "_digest_valid"}, 64'(digest_valid), 64'd0);
    chk({tag, "_byte_count"}, 64'(byte_count), 64'd0);
    chk({tag, "_msg_err"}, 64'(msg_err), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    int base, dvb, meb, g, len;
    rst = 1'b1; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready_after", 64'(in_ready), 64'd1);

    load_str("H4rdw4r3_Tr0j4n");
    base = pulse_cnt;
    send_msg(0);
    wait_idle();
    chk("h4_pulse_count", 64'(pulse_cnt - base), 64'd17);
    chk("h4_byte_count", 64'(byte_count), 64'd15);

    stalls = 0; dvb = dv_cnt;
    load_str("AlessandroAndGiacomo"); send_msg(0);
    load_str("3.141592653589793238"); send_msg(0);
    wait_idle();
    chk("fifo_full_stall_seen", 64'(stalls > 0), 64'd1);
    chk("b2b_digest_count", 64'(dv_cnt - dvb), 64'd2);
    chk("b2b_byte_count", 64'(byte_count), 64'd20);

    base = pulse_cnt; dvb = dv_cnt; meb = me_cnt;
    msg.delete();
    msg.push_back("A"); msg.push_back("B"); msg.push_back(8'hFF); msg.push_back("C"); msg.push_back("D");
    send_msg(0);
    wait_idle();
    chk("poison_pulse_count", 64'(pulse_cnt - base), 64'd4);
    chk("poison_msg_err", 64'(me_cnt - meb), 64'd1);
    chk("poison_no_digest", 64'(dv_cnt - dvb), 64'd0);
    load_str("Next!"); send_msg(0);
    wait_idle();

    busy_lat = 50;
    base = pulse_cnt;
    load_str("busy!!"); send_msg(0);
    wait_idle();
    busy_lat = 0;
    chk("busy_pulse_count", 64'(pulse_cnt - base), 64'd8);

    err_at = 3; base = pulse_cnt; meb = me_cnt;
    load_str("0123456789"); send_msg(3);
    wait_idle();
    err_at = 0;
    chk("err_pulse_count", 64'(pulse_cnt - base), 64'd5);
    chk("err_msg_err", 64'(me_cnt - meb), 64'd1);
    load_str("after"); send_msg(0);
    wait_idle();

    msg.delete();
    for (int i = 0; i < 40; i++) msg.push_back(8'($urandom_range(1, 254)));
    send_msg(0);
    wait_idle();
    chk("saturated_byte_count", 64'(byte_count), 64'd31);

    base = pulse_cnt;
    load_str("resetme!!!"); send_msg(0);
    idle_in();
    g = 0;
    while (pulse_cnt < base + 6 && g < 2000) begin @(negedge clk); g++; end
    if (g >= 2000) fail_now("mid_reset_wait", "got too few pulses required 6");
    @(negedge clk);
    rst = 1'b1;
    exp_pulse.delete(); exp_res.delete(); last_digest = '0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
    repeat (6) @(negedge clk);
    chk("midrst_fifo_empty_idle", 64'(busy), 64'd0);
    load_str("fresh"); send_msg(0);
    wait_idle();

    for (int it = 0; it < 12; it++) begin
      busy_lat = (it % 2 == 0) ? int'($urandom_range(0, 4)) : busy_lat;
      for (int m = 0; m < 2; m++) begin
        len = $urandom_range(1, 24);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(1, 254)));
        if ($urandom_range(0, 3) == 0) msg[$urandom_range(0, len - 1)] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        send_msg(0);
        if ($urandom_range(0, 1) == 1) begin
          idle_in();
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      wait_idle();
    end
    busy_lat = 0;

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    n_err++;
    $display("FAIL watchdog: got no completion required completion within 2ms");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $fatal(1);
  end

endmodule

// File: doc/lh_message_sequencer.md
Name: lh_message_sequencer

Overview:
Upstream feeder for light_hash. Accepts a host byte stream with valid/ready/last framing and buffers it in a small FIFO. Drives light_hash's single-byte pulse handshake: start marker 0xFF, then the message bytes, paced on the hasher's next_byte busy flag, then end marker 0x00. Captures the resulting 64-bit digest, or reports an error, once per message.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=4)
TIMEOUT, 1024, cycles allowed for hash_busy to clear or hash_digest_ready to assert before abort
CNT_W, 16, width of byte_count

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_byte  in  8  host message byte
in_valid  in  1  host byte valid
in_last  in  1  final byte of message, qualified by in_valid
in_ready  out  1  FIFO can accept
hash_byte  out  8  to light_hash message_byte
hash_valid  out  1  to light_hash message_valid
hash_busy  in  1  from light_hash next_byte
hash_digest  in  64  from light_hash digest
hash_digest_ready  in  1  from light_hash digest_ready
hash_err  in  1  from light_hash err_invalid_message_byte
digest  out  64  captured digest
digest_valid  out  1  1-cycle pulse, digest/byte_count valid
byte_count  out  CNT_W  message bytes sent (markers excluded), saturating
msg_err  out  1  1-cycle pulse, message aborted
busy  out  1  FSM not IDLE

Behaviour:
- Reset values: in_ready=0 during rst and 1 the cycle after; hash_byte=0, hash_valid=0, digest=0, digest_valid=0, byte_count=0, msg_err=0, busy=0. Reset also empties the FIFO and clears the drop flag. Reset mid-message discards everything and sends no end marker.
- FIFO: entries are {poison, last, byte[7:0]}. Push when in_valid&&in_ready; in_ready=!full. Full and empty come from the pointers plus a wrap bit. Pointers wrap modulo DEPTH. Simultaneous push/pop when full is not allowed (in_ready already 0); when empty, the pop waits.
- Reserved input: an in_byte of 0x00 or 0xFF is never stored. It pushes {poison=1,last=1}. If that beat is not in_last, the drop flag is set, and later beats are accepted (in_ready=!full) but discarded up to and including in_last.
- Hasher pulse rule: hash_valid is high for exactly 1 cycle with hash_byte stable in that cycle. After the pulse, hash_valid is low for at least 1 cycle. hash_byte holds its value until the next pulse.
- FSM:
 IDLE: FIFO non-empty -> START. busy=0.
 START: pulse 0xFF, clear byte counter -> GAP.
 GAP: one idle cycle -> FETCH.
 FETCH: empty -> stay (stall, no pulse). Head poison -> pop, go to END with abort flag set. Otherwise pop, pulse head byte, count+1 (saturate at 2^CNT_W-1) -> SETTLE.
 SETTLE: one idle cycle, then WAIT_BUSY.
 WAIT_BUSY: hash_busy==0 -> entry last ? END : FETCH. hash_err==1 in any state from START to WAIT_BUSY -> set abort flag -> FLUSH. Timer reaching TIMEOUT -> set abort flag -> END.
 END: pulse 0x00 -> WAIT_DIG. The timer restarts.
 WAIT_DIG: hash_digest_ready==1 -> if aborted, msg_err=1 and no digest update; else digest<=hash_digest, byte_count<=counter, digest_valid=1 -> IDLE. Timeout -> msg_err=1 -> IDLE.
 FLUSH: pop entries until the popped entry has last=1 (or stop at the poison entry); stall while empty; no pulses -> END.
- Latency: IDLE to the first hash_valid is 1 cycle. Pulse spacing is 2 cycles minimum when hash_busy is already low. A message of N bytes with a zero-latency hasher needs 2+N*3+1 pulse-related cycles plus digest wait.
- Only one message is in flight. Host bytes for the next message may fill the FIFO meanwhile.

Test Plan:
- Reset, then push "H4rdw4r3_Tr0j4n" (15 bytes, last on 'n') to a light_hash model -> 17 hash_valid pulses (0xFF, 15 bytes, 0x00); digest_valid with digest=f383664d125b1020, byte_count=15.
- Back-to-back "AlessandroAndGiacomo" then "3.141592653589793238" with in_valid held high -> in_ready drops at FIFO full; digests e19e79abcdf021f1 then f9e317d512022e21; byte_count=20 both times.
- Message "AB", 0xFF, "CD", last -> pulses 0xFF,'A','B',0x00; msg_err pulse; no digest_valid; the CD beats are accepted and dropped; the next message hashes correctly.
- Model holds hash_busy high for 50 cycles after each byte -> no pulse while busy; exactly 1 pulse per byte; hash_valid never high 2 consecutive cycles.
- Model asserts hash_err on byte 3 of a 10-byte message -> FLUSH pops the remaining 7 bytes, 0x00 sent, msg_err=1, digest unchanged.
- Assert rst mid-message (after 5 bytes) -> next cycle all outputs are at reset values and the FIFO is empty; a following message starts with 0xFF.
